// File: rtl/mul_seq_ctrl.sv
// Sequencer for a shift-and-add multiplier sharing one adder over WIDTH iterations.
// Stalls the datapath from start until the registered product is presented in DONE.
module mul_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic               iSigned,
  input  logic [WIDTH-1:0]   iOperandA,
  input  logic [WIDTH-1:0]   iOperandB,
  output logic               oStall,
  output logic               oBusy,
  output logic               oDone,
  output logic [2*WIDTH-1:0] oResult
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} stateT;

  stateT               state;
  stateT               nextState;
  logic [CNT_W-1:0]    counter;
  logic [WIDTH-1:0]    mA;
  logic [WIDTH-1:0]    mB;
  logic                neg;
  logic [2*WIDTH-1:0]  acc;

  // Unsigned magnitude; the most-negative value maps onto itself, which is
  // the correct magnitude when read as unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic isSigned);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    if (isSigned && s[WIDTH-1])
      return WIDTH'(-s);
    return v;
  endfunction

  function automatic logic [2*WIDTH-1:0] applySign(input logic [2*WIDTH-1:0] v,
                                                   input logic isNeg);
    logic signed [2*WIDTH-1:0] s;
    s = signed'(v);
    return isNeg ? (2*WIDTH)'(-s) : v;
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      state <= nextState;
      oBusy <= (nextState != IDLE);
      oDone <= (nextState == DONE);
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iStart) nextState = RUN;
      RUN:     if (counter == CNT_W'(WIDTH - 1)) nextState = FIX;
      FIX:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    oStall = 1'b0;
    case (state)
      IDLE:    oStall = iStart;
      RUN:     oStall = 1'b1;
      FIX:     oStall = 1'b1;
      default: oStall = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      counter <= '0;
      mA      <= '0;
      mB      <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      oResult <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (iStart) begin
            mA      <= magnitude(iOperandA, iSigned);
            mB      <= magnitude(iOperandB, iSigned);
            neg     <= iSigned & (iOperandA[WIDTH-1] ^ iOperandB[WIDTH-1]);
            acc     <= '0;
            counter <= '0;
          end
        end
        RUN: begin
          // One partial product per cycle; no early exit on a zero multiplier.
          if (mB[0])
            acc <= acc + ({{WIDTH{1'b0}}, mA} << counter);
          mB      <= mB >> 1;
          counter <= counter + CNT_W'(1);
        end
        FIX:     oResult <= applySign(acc, neg);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed scenarios plus random operands
// compared against a plain-arithmetic product model.
module tb_mul_seq_ctrl;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic        iSigned;
  logic [15:0] iOperandA;
  logic [15:0] iOperandB;
  logic        oStall;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;

  int checks   = 0;
  int failures = 0;
  logic [31:0] prevResult = '0;

  mul_seq_ctrl #(.WIDTH(16), .CNT_W(5)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .iStart    (iStart),
    .iSigned   (iSigned),
    .iOperandA (iOperandA),
    .iOperandB (iOperandB),
    .oStall    (oStall),
    .oBusy     (oBusy),
    .oDone     (oDone),
    .oResult   (oResult)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] refMul(input bit sgn, input logic [15:0] a,
                                         input logic [15:0] b);
    longint pa;
    longint pb;
    pa = sgn ? longint'($signed(a)) : longint'(a);
    pb = sgn ? longint'($signed(b)) : longint'(b);
    return 32'(pa * pb);
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // One full operation, cycle 0 = start cycle, checked cycle by cycle to cycle 19.
  task automatic runOp(input bit sgn, input logic [15:0] a, input logic [15:0] b,
                       input string tag);
    logic [31:0] expv;
    bit eStall, eBusy, eDone;
    expv = refMul(sgn, a, b);
    iStart = 1'b1; iSigned = sgn; iOperandA = a; iOperandB = b;
    for (int c = 0; c <= 19; c++) begin
      if (c >= 1) begin
        iStart    = 1'b0;
        iSigned   = 1'($urandom);
        iOperandA = 16'($urandom);
        iOperandB = 16'($urandom);
      end
      #1;
      eStall = (c <= 17);
      eBusy  = (c >= 1 && c <= 18);
      eDone  = (c == 18);
      checks += 3;
      if (oStall !== eStall) begin
        failures++;
        $display("FAIL %s stall c=%0d got=%b want=%b", tag, c, oStall, eStall);
      end
      if (oBusy !== eBusy) begin
        failures++;
        $display("FAIL %s busy c=%0d got=%b want=%b", tag, c, oBusy, eBusy);
      end
      if (oDone !== eDone) begin
        failures++;
        $display("FAIL %s done c=%0d got=%b want=%b", tag, c, oDone, eDone);
      end
      if (c == 17 || c >= 18) begin
        checks++;
        if (oResult !== ((c >= 18) ? expv : prevResult)) begin
          failures++;
          $display("FAIL %s result c=%0d got=%h want=%h", tag, c, oResult,
                   (c >= 18) ? expv : prevResult);
        end
      end
      tick();
    end
    prevResult = expv;
  endtask

  task automatic test_reset();
    Reset = 1'b1; iStart = 1'b0; iSigned = 1'b0; iOperandA = '0; iOperandB = '0;
    tick(); tick();
    Reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks += 4;
      if (oStall !== 1'b0) begin failures++; $display("FAIL reset stall got=%b want=0", oStall); end
      if (oBusy  !== 1'b0) begin failures++; $display("FAIL reset busy got=%b want=0", oBusy); end
      if (oDone  !== 1'b0) begin failures++; $display("FAIL reset done got=%b want=0", oDone); end
      if (oResult !== 32'h0) begin failures++; $display("FAIL reset result got=%h want=0", oResult); end
      tick();
    end
    prevResult = '0;
  endtask

  task automatic test_unsigned();
    runOp(1'b0, 16'hFFFF, 16'hFFFF, "unsigned_max");
    checks++;
    if (prevResult !== 32'hFFFE0001) begin
      failures++;
      $display("FAIL unsigned_model got=%h want=fffe0001", prevResult);
    end
  endtask

  task automatic test_signed();
    runOp(1'b1, 16'hFFFF, 16'h0001, "signed_m1x1");
    runOp(1'b1, 16'h8000, 16'h8000, "signed_minxmin");
    runOp(1'b1, 16'h0007, 16'hFFFD, "signed_7xm3");
    runOp(1'b1, 16'h0000, 16'h8001, "signed_zero");
    runOp(1'b0, 16'h8000, 16'h0002, "unsigned_msb");
  endtask

  task automatic test_disturb();
    bit nS;
    logic [15:0] nA, nB;
    logic [31:0] exp2, eRes;
    bit eStall, eBusy, eDone;
    nS = 1'($urandom); nA = 16'($urandom); nB = 16'($urandom);
    exp2 = refMul(nS, nA, nB);
    iStart = 1'b1; iSigned = 1'b1; iOperandA = 16'd3; iOperandB = 16'd5;
    for (int c = 0; c <= 38; c++) begin
      if (c >= 1 && c <= 18) begin
        iStart = 1'b1; iSigned = 1'($urandom);
        iOperandA = 16'($urandom); iOperandB = 16'($urandom);
      end else if (c == 19) begin
        iStart = 1'b1; iSigned = nS; iOperandA = nA; iOperandB = nB;
      end else if (c >= 20) begin
        iStart = 1'b0; iOperandA = 16'($urandom); iOperandB = 16'($urandom);
      end
      #1;
      eStall = (c <= 17) || (c >= 19 && c <= 36);
      eBusy  = (c >= 1 && c <= 18) || (c >= 20 && c <= 37);
      eDone  = (c == 18) || (c == 37);
      eRes   = (c <= 17) ? prevResult : (c <= 36) ? 32'h0000000F : exp2;
      checks += 4;
      if (oStall !== eStall) begin failures++; $display("FAIL disturb stall c=%0d got=%b want=%b", c, oStall, eStall); end
      if (oBusy !== eBusy) begin failures++; $display("FAIL disturb busy c=%0d got=%b want=%b", c, oBusy, eBusy); end
      if (oDone !== eDone) begin failures++; $display("FAIL disturb done c=%0d got=%b want=%b", c, oDone, eDone); end
      if (oResult !== eRes) begin failures++; $display("FAIL disturb result c=%0d got=%h want=%h", c, oResult, eRes); end
      tick();
    end
    prevResult = exp2;
  endtask

  task automatic test_reset_mid();
    iStart = 1'b1; iSigned = 1'b0; iOperandA = 16'd100; iOperandB = 16'd200;
    for (int c = 0; c <= 30; c++) begin
      if (c >= 1) iStart = 1'b0;
      Reset = (c == 8);
      #1;
      if (c >= 1 && c <= 7) begin
        checks++;
        if (oBusy !== 1'b1) begin failures++; $display("FAIL rstmid busy c=%0d got=%b want=1", c, oBusy); end
      end
      if (c >= 9) begin
        checks += 4;
        if (oBusy !== 1'b0) begin failures++; $display("FAIL rstmid busy c=%0d got=%b want=0", c, oBusy); end
        if (oDone !== 1'b0) begin failures++; $display("FAIL rstmid done c=%0d got=%b want=0", c, oDone); end
        if (oStall !== 1'b0) begin failures++; $display("FAIL rstmid stall c=%0d got=%b want=0", c, oStall); end
        if (oResult !== 32'h0) begin failures++; $display("FAIL rstmid result c=%0d got=%h want=0", c, oResult); end
      end
      tick();
    end
    prevResult = '0;
    runOp(1'b1, 16'd2, 16'd3, "after_reset");
  endtask

  task automatic test_back_to_back();
    int ph;
    iStart = 1'b1; iSigned = 1'b0; iOperandA = 16'h0010; iOperandB = 16'h0010;
    for (int c = 0; c < 3 * 19; c++) begin
      ph = c % 19;
      #1;
      checks += 3;
      if (oStall !== (ph != 18)) begin failures++; $display("FAIL b2b stall c=%0d got=%b want=%b", c, oStall, ph != 18); end
      if (oBusy !== (ph != 0)) begin failures++; $display("FAIL b2b busy c=%0d got=%b want=%b", c, oBusy, ph != 0); end
      if (oDone !== (ph == 18)) begin failures++; $display("FAIL b2b done c=%0d got=%b want=%b", c, oDone, ph == 18); end
      if (ph == 18) begin
        checks++;
        if (oResult !== 32'h00000100) begin failures++; $display("FAIL b2b result c=%0d got=%h want=00000100", c, oResult); end
      end
      tick();
    end
    iStart = 1'b0;
    tick();
    prevResult = 32'h00000100;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      runOp(1'($urandom), 16'($urandom), 16'($urandom), $sformatf("rand%0d", i));
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_disturb();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
